pads_cfg_master: RTL and testbench
==================================

# pads_cfg_master

Wishbone initiator that programs the pad output-enable configuration slave at 0x3000_6000. On a start pulse it latches a target OEN vector and writes one word per pad index (byte address = base + index), optionally reading each back to verify. It sits beside the management-side Wishbone interconnect and replaces firmware loops for pad bring-up.

## Interface

- NUM_PADS, 38, number of pad indices written, 0..NUM_PADS-1 (slave decodes 0x00..0x25); max 64
- BASE_ADDR, 32'h3000_6000, address of pad index 0
- TIMEOUT, 15, cycles stb may wait for ack before abort (1..255)

Ports:

- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle request; ignored while busy_o=1
- oen_i  in  NUM_PADS  target OEN per pad, sampled only in the start cycle
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse at sequence end (success or abort)
- err_o  out  1  sticky error, cleared by next accepted start
- err_mis_o  out  1  error cause: 1 = readback mismatch, 0 = ack timeout
- err_idx_o  out  6  pad index at which the error occurred
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  1 = write, 0 = read
- wbm_sel_o  out  4  always 4'hF
- wbm_adr_o  out  32  BASE_ADDR + index
- wbm_dat_o  out  32  {31'b0, oen[index]}
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  32  read data, only bit 0 is checked

## Operation

- States: IDLE, REQ, GAP, DONE. With verification enabled, REQ runs twice per index, write then read.
- IDLE: when start_i=1, latch oen_i into a shadow register, clear index and all error fields, and go to REQ (write).
- REQ: drive cyc=stb=1 with the address and data for the current index.
  - On ack: drop cyc and stb at the next edge and go to GAP.
  - With no ack, the timeout counter increments each cycle. When it reaches TIMEOUT: drop cyc/stb, set err_o=1, err_mis_o=0, err_idx_o=index, and go to DONE.
- GAP: one idle cycle with cyc=stb=0, and wbm_ack_i is ignored. This is mandatory because the slave's registered ack stays high for one cycle after stb falls.
  - If this was the last index and the last phase, go to DONE.
  - Otherwise increment the index (or switch write→read) and return to REQ.
- DONE: done_o=1 for one cycle, busy_o=0, then go to IDLE.
- The index never wraps. The sequence ends at NUM_PADS-1.
- wbm_adr_o, wbm_dat_o and wbm_we_o hold stable for the whole REQ phase. They are don't-care outside REQ.
- Reset values: cyc, stb, we, busy, done, err_o, err_mis_o = 0; err_idx_o = 0; adr and dat = 0; state = IDLE.
- Reset asserted mid-transfer drops cyc/stb immediately (asynchronously). No done pulse is generated.

## Timing

- Cycle 0 is the start_i cycle.
- Pad i write: stb high in cycle 3i+1. With a 1-cycle slave, ack arrives in 3i+2 and the gap is in 3i+3.
- With NUM_PADS=38 and no verification: last gap is cycle 114, done_o is high in cycle 115, busy_o is high in cycles 1..114.
- With verification: 6 cycles per pad, done_o in cycle 6·NUM_PADS+1.
- Timeout: stb stays high for exactly TIMEOUT cycles. done_o follows 1 cycle after the last stb cycle.
- A start_i pulse that coincides with done_o is ignored.

## Configuration

- PADS_CFG_VERIFY_EN defined:
  - Each write is followed by a read of the same address.
  - If wbm_dat_i[0] differs from oen[i] at the read ack, set err_o=1, err_mis_o=1, err_idx_o=i, and go through GAP to DONE.
- PADS_CFG_VERIFY_EN undefined:
  - Write-only sequence; the read path and comparator are absent.
  - err_mis_o is tied to 0 and wbm_dat_i is unused.

## Structure

- Shared package pads_cfg_pkg holds:
  - the state enum (IDLE/REQ/GAP/DONE)
  - PADS_CFG_BASE = 32'h3000_6000
  - PADS_CFG_NUM = 38
  - the index width constant (6)
- One sub-module, pads_cfg_wb_xfer: a single-transfer engine that owns cyc/stb, the timeout counter and the ack/GAP handling, and returns xfer_ok/xfer_tmo pulses. The top level owns the index, the phase and the error bookkeeping.

## Test plan

- Reset, then start with oen_i = 38'h3F_FFC0_0041 and a 1-cycle-ack slave model → 38 writes to addresses 0x3000_6000..0x3000_6025 carrying bit i of the vector; done_o in cycle 115; err_o=0.
- Slave keeps ack high one extra cycle after stb falls → that ack is ignored in GAP; exactly 38 transfers occur.
- Slave never acks index 5 → stb high for 15 cycles at 0x3000_6005, then done_o, err_o=1, err_mis_o=0, err_idx_o=5.
- PADS_CFG_VERIFY_EN with the slave returning an inverted bit 0 at index 12 → write/read pairs for 0..12, then err_mis_o=1, err_idx_o=12, done_o.
- wb_rst_i pulsed while REQ is active at index 20 → cyc/stb drop in the same cycle, no done_o; a new start begins again at index 0.
- start_i pulsed again while busy, and a start in the done_o cycle → both ignored; the sequence and its timing are unchanged.

Source files
------------

// File: rtl/pads_cfg_pkg.sv
// Shared types and constants for the pad output-enable configuration master.
// Feature macro: PADS_CFG_VERIFY_EN (read-back verify of every pad write).
package pads_cfg_pkg;

   localparam logic [31:0] PADS_CFG_BASE  = 32'h3000_6000;
   localparam int          PADS_CFG_NUM   = 38;
   localparam int          PADS_CFG_IDX_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } pads_cfg_st_e;

endpackage

// File: rtl/pads_cfg_wb_xfer.sv
// Single Wishbone transfer engine: owns cyc/stb, the ack timeout and the post-ack gap cycle.
// xfer_ok_o pulses in the gap cycle; xfer_tmo_o pulses in the last unacknowledged strobe cycle.
module pads_cfg_wb_xfer
   import pads_cfg_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic launch_i,
   input  logic ack_i,
   output logic cyc_o,
   output logic stb_o,
   output logic ack_o,
   output logic xfer_ok_o,
   output logic xfer_tmo_o
);

   pads_cfg_st_e state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ack_o      = 1'b0;
      xfer_ok_o  = 1'b0;
      xfer_tmo_o = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (launch_i) state_d = REQ;
         end
         REQ: begin
            if (ack_i) begin
               ack_o   = 1'b1;
               cnt_d   = 8'd0;
               state_d = GAP;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               xfer_tmo_o = 1'b1;
               cnt_d      = 8'd0;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         // The slave's registered ack may still be high here; it is deliberately not looked at.
         GAP: begin
            xfer_ok_o = 1'b1;
            state_d   = launch_i ? REQ : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cyc_o = (state_q == REQ);
   assign stb_o = (state_q == REQ);

endmodule

// File: rtl/pads_cfg_master.sv
// Wishbone initiator writing one OEN word per pad index; PADS_CFG_VERIFY_EN adds a read-back per pad.
// Latency 3 cycles per pad (6 with verify) with a 1-cycle slave; stalls on ack, aborts after TIMEOUT.
module pads_cfg_master
   import pads_cfg_pkg::*;
#(
   parameter int          NUM_PADS  = PADS_CFG_NUM,
   parameter logic [31:0] BASE_ADDR = PADS_CFG_BASE,
   parameter int          TIMEOUT   = 15
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic                      start_i,
   input  logic [NUM_PADS-1:0]       oen_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o,
   output logic                      err_mis_o,
   output logic [PADS_CFG_IDX_W-1:0] err_idx_o,
   output logic                      wbm_cyc_o,
   output logic                      wbm_stb_o,
   output logic                      wbm_we_o,
   output logic [3:0]                wbm_sel_o,
   output logic [31:0]               wbm_adr_o,
   output logic [31:0]               wbm_dat_o,
   input  logic                      wbm_ack_i,
   input  logic [31:0]               wbm_dat_i
);

   // Top-level sequence uses IDLE/REQ/DONE; the GAP cycle lives inside the transfer engine.
   pads_cfg_st_e              state_q, state_d;
   logic [NUM_PADS-1:0]       oen_q, oen_d;
   logic [PADS_CFG_IDX_W-1:0] idx_q, idx_d;
   logic [PADS_CFG_IDX_W-1:0] err_idx_q, err_idx_d;
   logic                      err_q, err_d;
   logic                      mis_q, mis_d;
   logic                      launch, xfer_ack, xfer_ok, xfer_tmo;
   logic                      phase_q, last_phase, rd_bad, cur_bit, last;

`ifdef PADS_CFG_VERIFY_EN
   logic phase_d;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) phase_q <= 1'b0;
      else          phase_q <= phase_d;
   end

   assign last_phase = phase_q;
   assign rd_bad     = xfer_ack && phase_q && (wbm_dat_i[0] != cur_bit);
`else
   logic unused_dat;

   assign phase_q    = 1'b0;
   assign last_phase = 1'b1;
   assign rd_bad     = 1'b0;
   assign unused_dat = ^wbm_dat_i;
`endif

   assign cur_bit = oen_q[idx_q];
   assign last    = (idx_q == PADS_CFG_IDX_W'(NUM_PADS - 1)) && last_phase;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         oen_q     <= '0;
         idx_q     <= '0;
         err_idx_q <= '0;
         err_q     <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         oen_q     <= oen_d;
         idx_q     <= idx_d;
         err_idx_q <= err_idx_d;
         err_q     <= err_d;
         mis_q     <= mis_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      oen_d     = oen_q;
      idx_d     = idx_q;
      err_idx_d = err_idx_q;
      err_d     = err_q;
      mis_d     = mis_q;
      launch    = 1'b0;
`ifdef PADS_CFG_VERIFY_EN
      phase_d   = phase_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               oen_d     = oen_i;
               idx_d     = '0;
               err_d     = 1'b0;
               mis_d     = 1'b0;
               err_idx_d = '0;
               launch    = 1'b1;
               state_d   = REQ;
`ifdef PADS_CFG_VERIFY_EN
               phase_d   = 1'b0;
`endif
            end
         end
         REQ: begin
            if (xfer_tmo) begin
               err_d     = 1'b1;
               mis_d     = 1'b0;
               err_idx_d = idx_q;
               state_d   = DONE;
            end
            if (rd_bad) begin
               err_d     = 1'b1;
               mis_d     = 1'b1;
               err_idx_d = idx_q;
            end
            // Only a read mismatch can have set err_q while still in REQ.
            if (xfer_ok) begin
               if (last || err_q) begin
                  state_d = DONE;
               end else begin
                  launch = 1'b1;
`ifdef PADS_CFG_VERIFY_EN
                  if (!phase_q) begin
                     phase_d = 1'b1;
                  end else begin
                     phase_d = 1'b0;
                     idx_d   = idx_q + 1'b1;
                  end
`else
                  idx_d = idx_q + 1'b1;
`endif
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   pads_cfg_wb_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .launch_i   (launch),
      .ack_i      (wbm_ack_i),
      .cyc_o      (wbm_cyc_o),
      .stb_o      (wbm_stb_o),
      .ack_o      (xfer_ack),
      .xfer_ok_o  (xfer_ok),
      .xfer_tmo_o (xfer_tmo)
   );

   assign busy_o    = (state_q == REQ);
   assign done_o    = (state_q == DONE);
   assign err_o     = err_q;
   assign err_mis_o = mis_q;
   assign err_idx_o = err_idx_q;
   assign wbm_sel_o = 4'hF;
   assign wbm_we_o  = wbm_stb_o & ~phase_q;
   assign wbm_adr_o = wbm_stb_o ? (BASE_ADDR + 32'(idx_q)) : 32'd0;
   assign wbm_dat_o = wbm_stb_o ? {31'd0, cur_bit} : 32'd0;

endmodule

// File: tb/tb_pads_cfg_master.sv
// Directed bench for pads_cfg_master: main sequence, lingering ack, timeout, reset abort, ignored starts.
// Works for both builds; the mismatch scenario only runs with PADS_CFG_VERIFY_EN.
module tb_pads_cfg_master;

`ifdef PADS_CFG_VERIFY_EN
   localparam int K = 2;
`else
   localparam int K = 1;
`endif
   localparam int          N    = 38;
   localparam logic [31:0] BASE = 32'h3000_6000;

   logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0;
   logic [N-1:0] oen_i = '0;
   logic        busy_o, done_o, err_o, err_mis_o;
   logic [5:0]  err_idx_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

   pads_cfg_master dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .oen_i(oen_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_mis_o(err_mis_o),
      .err_idx_o(err_idx_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
      .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
      .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Slave model: registered ack, optional lingering ack, one mute index, one inverted read index.
   logic        ack_q;
   logic        extra_ack = 1'b0;
   int          noack_idx = -1, inv_idx = -1;
   logic [63:0] mem;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q <= 1'b0;
      end else begin
         if (wbm_cyc_o && wbm_stb_o && int'(wbm_adr_o[5:0]) != noack_idx)
            ack_q <= extra_ack ? 1'b1 : ~ack_q;
         else if (extra_ack && ack_q && !wbm_stb_o)
            ack_q <= 1'b0;
         else
            ack_q <= extra_ack ? (ack_q & wbm_stb_o) : 1'b0;
         if (wbm_cyc_o && wbm_stb_o && wbm_we_o) mem[wbm_adr_o[5:0]] <= wbm_dat_o[0];
      end
   end

   assign wbm_ack_i = ack_q;
   assign wbm_dat_i = {31'd0, mem[wbm_adr_o[5:0]] ^ (int'(wbm_adr_o[5:0]) == inv_idx)};

   // Monitor: cycle numbering is relative to the start_i cycle (t0).
   int       cyc_cnt = 0, t0 = 0;
   int       wr_cnt, rd_cnt, stb_cycles, busy_cycles, done_cnt, done_cyc, first_stb;
   logic [31:0] last_adr;
   logic [N-1:0] exp_oen;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (wbm_cyc_o && wbm_stb_o) begin
            if (first_stb < 0) first_stb = cyc_cnt - t0;
            stb_cycles++;
            last_adr = wbm_adr_o;
            if (wbm_ack_i) begin
               if (wbm_we_o) begin
                  chk("wr_adr", wbm_adr_o, BASE + 32'(wr_cnt));
                  chk("wr_dat", wbm_dat_o, {63'd0, exp_oen[wr_cnt]});
                  wr_cnt++;
               end else begin
                  chk("rd_adr", wbm_adr_o, BASE + 32'(rd_cnt));
                  rd_cnt++;
               end
            end
         end
         if (busy_o) busy_cycles++;
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc_cnt - t0;
         end
      end
   end

   task automatic start_seq(input logic [N-1:0] v);
      @(posedge clk); #1;
      wr_cnt = 0; rd_cnt = 0; stb_cycles = 0; busy_cycles = 0;
      done_cnt = 0; done_cyc = -1; first_stb = -1;
      exp_oen = v; oen_i = v; start_i = 1'b1; t0 = cyc_cnt;
      @(posedge clk); #1;
      start_i = 1'b0; oen_i = '0;
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (done_cnt == 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == 0) chk("done_seen", 64'd0, 64'd1);
   endtask

   localparam int MAIN_DONE = 3 * K * N + 1;

   initial begin
      mem = '0;
      #23;
      chk("rst_cyc", wbm_cyc_o, 0);
      chk("rst_stb", wbm_stb_o, 0);
      chk("rst_we", wbm_we_o, 0);
      chk("rst_flags", {busy_o, done_o, err_o, err_mis_o}, 0);
      chk("rst_err_idx", err_idx_o, 0);
      chk("rst_adr", wbm_adr_o, 0);
      chk("rst_dat", wbm_dat_o, 0);
      rst = 1'b0;

      // Main sequence with a 1-cycle slave.
      start_seq(38'h3F_FFC0_0041);
      wait_done(1000);
      chk("main_done_cyc", done_cyc, MAIN_DONE);
      chk("main_err", err_o, 0);
      chk("main_first_stb", first_stb, 1);
      chk("main_sel", wbm_sel_o, 4'hF);
      chk("main_writes", wr_cnt, N);
      chk("main_reads", rd_cnt, (K - 1) * N);
      chk("main_stb_cycles", stb_cycles, 2 * K * N);
      chk("main_busy_cycles", busy_cycles, MAIN_DONE - 1);

      // Ack lingers one cycle after stb falls; the gap must ignore it.
      extra_ack = 1'b1;
      start_seq(38'h15_5555_AAAA);
      wait_done(1000);
      chk("linger_done_cyc", done_cyc, MAIN_DONE);
      chk("linger_writes", wr_cnt, N);
      chk("linger_stb_cycles", stb_cycles, 2 * K * N);
      chk("linger_err", err_o, 0);
      extra_ack = 1'b0;

      // Index 5 never acknowledged: 15 strobe cycles then abort.
      noack_idx = 5;
      start_seq(38'h00_0000_0020);
      wait_done(1000);
      chk("tmo_done_cyc", done_cyc, 3 * K * 5 + 1 + 15);
      chk("tmo_stb_cycles", stb_cycles, 2 * K * 5 + 15);
      chk("tmo_last_adr", last_adr, BASE + 32'd5);
      chk("tmo_err", {err_o, err_mis_o}, 2'b10);
      chk("tmo_err_idx", err_idx_o, 5);
      chk("tmo_writes", wr_cnt, 5);
      noack_idx = -1;

`ifdef PADS_CFG_VERIFY_EN
      // Read-back of index 12 returns the inverted bit.
      inv_idx = 12;
      start_seq(38'h2A_5A5A_1234);
      wait_done(1000);
      chk("mis_done_cyc", done_cyc, 6 * 12 + 7);
      chk("mis_err", {err_o, err_mis_o}, 2'b11);
      chk("mis_err_idx", err_idx_o, 12);
      chk("mis_writes", wr_cnt, 13);
      chk("mis_reads", rd_cnt, 13);
      inv_idx = -1;
`endif

      // Reset while the write of index 20 is strobing.
      start_seq(38'h3F_FFFF_FFFF);
      begin
         int n = 0;
         while (!(wbm_stb_o && wbm_adr_o == BASE + 32'd20) && n < 1000) begin
            @(negedge clk);
            n++;
         end
         chk("rst_mid_reached", wbm_adr_o, BASE + 32'd20);
      end
      rst = 1'b1;
      #1;
      chk("rst_mid_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 2'b00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_no_done", done_cnt, 0);
      chk("rst_mid_busy", busy_o, 0);
      start_seq(38'h01_0203_0405);
      wait_done(1000);
      chk("restart_done_cyc", done_cyc, MAIN_DONE);
      chk("restart_writes", wr_cnt, N);

      // Starts while busy and in the done cycle are ignored.
      start_seq(38'h0F_0F0F_0F0F);
      repeat (9) @(posedge clk);
      #1 start_i = 1'b1; oen_i = ~exp_oen;
      @(posedge clk);
      #1 start_i = 1'b0; oen_i = '0;
      repeat (MAIN_DONE - 11) @(posedge clk);
      #1 start_i = 1'b1; oen_i = ~exp_oen;
      @(posedge clk);
      #1 start_i = 1'b0; oen_i = '0;
      repeat (5) @(posedge clk);
      #1;
      chk("ign_done_cyc", done_cyc, MAIN_DONE);
      chk("ign_done_cnt", done_cnt, 1);
      chk("ign_stb_cycles", stb_cycles, 2 * K * N);
      chk("ign_busy_after", busy_o, 0);
      chk("ign_writes", wr_cnt, N);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
